// File: rtl/spio_hss_multiplexer_spi_reg_if.sv
// ============================================================================
// Module   : spio_hss_multiplexer_spi_reg_if
// Brief    : SPI mode-0 slave bridge into the HSS multiplexer register bank,
//            oversampled entirely in the clk domain.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spio_hss_multiplexer_spi_reg_if #(
   parameter int REGA_BITS = 5,
   parameter int REGD_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 spi_sck,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 reg_write,
   output logic [REGA_BITS-1:0] reg_addr,
   output logic [REGD_BITS-1:0] reg_write_data,
   input  logic [REGD_BITS-1:0] reg_read_data,
   output logic                 spi_abrt
);

   // Counter must hold both the 8-bit command count and the data count.
   localparam int CNT_RAW = $clog2(REGD_BITS) + 1;
   localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_RCAP  = 3'd2,
      ST_WDATA = 3'd3,
      ST_RDATA = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   logic                 sck_s1_q, sck_s2_q, sck_s3_q;
   logic                 cs_s1_q, cs_s2_q;
   logic                 mosi_s1_q, mosi_s2_q;
   logic                 vld1_q, vld2_q;
   logic                 armed_q;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [6:0]           cmd_q;
   logic [REGD_BITS-1:0] wsh_q;
   logic [REGD_BITS-1:0] rsh_q;
   logic                 miso_q;
   logic                 wr_q;
   logic                 abrt_q;
   logic [REGA_BITS-1:0] addr_q;
   logic [REGD_BITS-1:0] wdata_q;

   logic                 w_rise;
   logic                 w_fall;
   logic [7:0]           w_cmd;
   logic [REGD_BITS-1:0] w_wword;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_s1_q  <= 1'b0;
         sck_s2_q  <= 1'b0;
         sck_s3_q  <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         vld1_q    <= 1'b0;
         vld2_q    <= 1'b0;
      end else begin
         sck_s1_q  <= spi_sck;
         sck_s2_q  <= sck_s1_q;
         sck_s3_q  <= sck_s2_q;
         cs_s1_q   <= spi_cs_n;
         cs_s2_q   <= cs_s1_q;
         mosi_s1_q <= spi_mosi;
         mosi_s2_q <= mosi_s1_q;
         vld1_q    <= 1'b1;
         vld2_q    <= vld1_q;
      end
   end

   assign w_rise  = sck_s2_q & ~sck_s3_q;
   assign w_fall  = ~sck_s2_q & sck_s3_q;
   assign w_cmd   = {cmd_q, mosi_s2_q};
   assign w_wword = REGD_BITS'({wsh_q, mosi_s2_q});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         cmd_q   <= '0;
         wsh_q   <= '0;
         rsh_q   <= '0;
         miso_q  <= 1'b0;
         wr_q    <= 1'b0;
         abrt_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         wr_q   <= 1'b0;
         abrt_q <= 1'b0;

         // Arm only once the synchroniser carries a real pin value that is high,
         // so a frame already running at reset release is skipped.
         if (vld2_q && cs_s2_q) begin
            armed_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               cnt_q  <= '0;
               miso_q <= 1'b0;
               if (armed_q && !cs_s2_q) begin
                  state_q <= ST_CMD;
               end
            end

            ST_CMD: begin
               if (cs_s2_q) begin
                  state_q <= ST_IDLE;
                  abrt_q  <= 1'b1;
                  cnt_q   <= '0;
                  miso_q  <= 1'b0;
               end else if (w_rise) begin
                  cmd_q <= w_cmd[6:0];
                  if (cnt_q == CNT_W'(7)) begin
                     cnt_q   <= '0;
                     addr_q  <= REGA_BITS'(w_cmd);
                     state_q <= w_cmd[7] ? ST_WDATA : ST_RCAP;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            ST_RCAP: begin
               if (cs_s2_q) begin
                  state_q <= ST_IDLE;
                  abrt_q  <= 1'b1;
                  cnt_q   <= '0;
                  miso_q  <= 1'b0;
               end else begin
                  rsh_q   <= reg_read_data;
                  state_q <= ST_RDATA;
               end
            end

            ST_WDATA: begin
               if (cs_s2_q) begin
                  state_q <= ST_IDLE;
                  abrt_q  <= 1'b1;
                  cnt_q   <= '0;
                  miso_q  <= 1'b0;
               end else if (w_rise) begin
                  wsh_q <= w_wword;
                  if (cnt_q == CNT_W'(REGD_BITS - 1)) begin
                     cnt_q   <= '0;
                     wdata_q <= w_wword;
                     wr_q    <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            ST_RDATA: begin
               if (cs_s2_q) begin
                  state_q <= ST_IDLE;
                  abrt_q  <= 1'b1;
                  cnt_q   <= '0;
                  miso_q  <= 1'b0;
               end else begin
                  if (w_fall) begin
                     miso_q <= rsh_q[REGD_BITS-1];
                     rsh_q  <= {rsh_q[REGD_BITS-2:0], 1'b0};
                  end
                  if (w_rise) begin
                     if (cnt_q == CNT_W'(REGD_BITS - 1)) begin
                        cnt_q   <= '0;
                        miso_q  <= 1'b0;
                        state_q <= ST_DONE;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
            end

            ST_DONE: begin
               cnt_q  <= '0;
               miso_q <= 1'b0;
               if (cs_s2_q) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               miso_q  <= 1'b0;
            end
         endcase
      end
   end

   assign spi_miso       = miso_q;
   assign reg_write      = wr_q;
   assign reg_addr       = addr_q;
   assign reg_write_data = wdata_q;
   assign spi_abrt       = abrt_q;

endmodule

`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_spi_reg_if.sv
// ============================================================================
// Module   : tb_spio_hss_multiplexer_spi_reg_if
// Brief    : Directed self-checking bench for the SPI register bridge.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spio_hss_multiplexer_spi_reg_if;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sck;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;
   logic        reg_write;
   logic [4:0]  reg_addr;
   logic [31:0] reg_write_data;
   logic [31:0] reg_read_data;
   logic        spi_abrt;

   int vectors     = 0;
   int miscompares = 0;

   int          wr_cycles   = 0;
   int          abrt_cycles = 0;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   logic [31:0] mem [0:31];

   always #5 clk = ~clk;

   spio_hss_multiplexer_spi_reg_if #(
      .REGA_BITS (5),
      .REGD_BITS (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .spi_sck        (spi_sck),
      .spi_cs_n       (spi_cs_n),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .reg_write      (reg_write),
      .reg_addr       (reg_addr),
      .reg_write_data (reg_write_data),
      .reg_read_data  (reg_read_data),
      .spi_abrt       (spi_abrt)
   );

   // Register bank: fixed contents at 3 and 5, everything else holds writes.
   assign reg_read_data = (reg_addr == 5'd3) ? 32'hDEAD_BEEF :
                          (reg_addr == 5'd5) ? 32'hA5A5_0F0F : mem[reg_addr];

   always @(posedge clk) begin
      if (reg_write) mem[reg_addr] <= reg_write_data;
   end

   always @(negedge clk) begin
      if (reg_write) begin
         wr_cycles = wr_cycles + 1;
         wr_addr   = reg_addr;
         wr_data   = reg_write_data;
      end
      if (spi_abrt) abrt_cycles = abrt_cycles + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mon();
      wr_cycles   = 0;
      abrt_cycles = 0;
   endtask

   task automatic spi_begin();
      spi_sck  = 1'b0;
      spi_cs_n = 1'b0;
      wait_clk(6);
   endtask

   task automatic spi_end(input int gap);
      wait_clk(HALF);
      spi_cs_n = 1'b1;
      wait_clk(gap);
   endtask

   // Sends bits[n-1] first; cap collects MISO as seen at each rising edge.
   task automatic spi_xfer(input logic [63:0] bits, input int n,
                           output logic [63:0] cap, output int miso_hi);
      cap     = '0;
      miso_hi = 0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = bits[i];
         wait_clk(HALF);
         cap = {cap[62:0], spi_miso};
         if (spi_miso) miso_hi++;
         spi_sck = 1'b1;
         wait_clk(HALF);
         spi_sck = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      spi_sck  = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      wait_clk(4);
      vectors++;
      if ({spi_miso, reg_write, spi_abrt} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b expected 000", {spi_miso, reg_write, spi_abrt});
      end
      vectors++;
      if (reg_addr !== 5'd0 || reg_write_data !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_regs: got addr %h data %h expected 00 00000000", reg_addr, reg_write_data);
      end
      rst = 1'b1;
      wait_clk(10);
   endtask

   task automatic test_write();
      logic [63:0] cap;
      int          hi;
      clear_mon();
      spi_begin();
      spi_xfer(64'h8A, 8, cap, hi);
      spi_xfer(64'h0000_0123, 32, cap, hi);
      spi_end(8);
      vectors++;
      if (wr_cycles !== 1) begin
         miscompares++;
         $display("FAIL write_pulses: got %0d expected 1", wr_cycles);
      end
      vectors++;
      if (wr_addr !== 5'h0A) begin
         miscompares++;
         $display("FAIL write_addr: got %h expected 0a", wr_addr);
      end
      vectors++;
      if (wr_data !== 32'h0000_0123) begin
         miscompares++;
         $display("FAIL write_data: got %h expected 00000123", wr_data);
      end
      vectors++;
      if (abrt_cycles !== 0) begin
         miscompares++;
         $display("FAIL write_abrt: got %0d expected 0", abrt_cycles);
      end
      vectors++;
      if (reg_write_data !== 32'h0000_0123 || reg_write !== 1'b0) begin
         miscompares++;
         $display("FAIL write_hold: got data %h wr %b expected 00000123 0", reg_write_data, reg_write);
      end
   endtask

   task automatic test_read();
      logic [63:0] cap;
      int          hi;
      clear_mon();
      spi_begin();
      spi_xfer(64'h03, 8, cap, hi);
      vectors++;
      if (hi !== 0) begin
         miscompares++;
         $display("FAIL read_cmd_miso: got %0d high bits expected 0", hi);
      end
      spi_xfer(64'h0, 32, cap, hi);
      spi_end(8);
      vectors++;
      if (cap[31:0] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL read_data: got %h expected deadbeef", cap[31:0]);
      end
      vectors++;
      if (wr_cycles !== 0) begin
         miscompares++;
         $display("FAIL read_no_write: got %0d expected 0", wr_cycles);
      end
      vectors++;
      if (reg_addr !== 5'd3) begin
         miscompares++;
         $display("FAIL read_addr: got %h expected 03", reg_addr);
      end
   endtask

   task automatic test_abort();
      logic [63:0] cap;
      int          hi;
      clear_mon();
      spi_begin();
      spi_xfer(64'h85, 8, cap, hi);
      spi_xfer(64'h000F_FFFF, 20, cap, hi);
      spi_end(8);
      vectors++;
      if (wr_cycles !== 0) begin
         miscompares++;
         $display("FAIL abort_no_write: got %0d expected 0", wr_cycles);
      end
      vectors++;
      if (abrt_cycles !== 1) begin
         miscompares++;
         $display("FAIL abort_pulse: got %0d cycles expected 1", abrt_cycles);
      end
      vectors++;
      if (reg_addr !== 5'd5) begin
         miscompares++;
         $display("FAIL abort_addr_hold: got %h expected 05", reg_addr);
      end
      clear_mon();
      spi_begin();
      spi_xfer(64'h05, 8, cap, hi);
      spi_xfer(64'h0, 32, cap, hi);
      spi_end(8);
      vectors++;
      if (cap[31:0] !== 32'hA5A5_0F0F) begin
         miscompares++;
         $display("FAIL abort_then_read: got %h expected a5a50f0f", cap[31:0]);
      end
      vectors++;
      if (abrt_cycles !== 0 || wr_cycles !== 0) begin
         miscompares++;
         $display("FAIL abort_then_read_strobes: got abrt %0d wr %0d expected 0 0", abrt_cycles, wr_cycles);
      end
   endtask

   task automatic test_overrun();
      logic [63:0] cap;
      int          hi;
      int          hi_total;
      clear_mon();
      spi_begin();
      spi_xfer(64'h87, 8, cap, hi);
      hi_total = hi;
      spi_xfer({16'h0, 32'h1357_9BDF, 16'hFFFF}, 48, cap, hi);
      hi_total += hi;
      spi_end(8);
      vectors++;
      if (wr_cycles !== 1) begin
         miscompares++;
         $display("FAIL overrun_pulses: got %0d expected 1", wr_cycles);
      end
      vectors++;
      if (wr_data !== 32'h1357_9BDF || wr_addr !== 5'd7) begin
         miscompares++;
         $display("FAIL overrun_word: got %h @%h expected 13579bdf @07", wr_data, wr_addr);
      end
      vectors++;
      if (hi_total !== 0) begin
         miscompares++;
         $display("FAIL overrun_miso: got %0d high bits expected 0", hi_total);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] cap;
      int          hi;
      clear_mon();
      spi_begin();
      spi_xfer(64'h03, 8, cap, hi);
      spi_xfer(64'h0, 10, cap, hi);
      rst = 1'b0;
      #1;
      vectors++;
      if ({spi_miso, reg_write, spi_abrt} !== 3'b000 || reg_addr !== 5'd0 || reg_write_data !== 32'd0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got miso %b wr %b abrt %b addr %h data %h expected all 0",
                  spi_miso, reg_write, spi_abrt, reg_addr, reg_write_data);
      end
      wait_clk(3);
      rst = 1'b1;
      spi_xfer(64'h0, 22, cap, hi);
      spi_end(8);
      vectors++;
      if (hi !== 0 || wr_cycles !== 0 || abrt_cycles !== 0) begin
         miscompares++;
         $display("FAIL midreset_remainder: got miso_hi %0d wr %0d abrt %0d expected 0 0 0",
                  hi, wr_cycles, abrt_cycles);
      end
      clear_mon();
      spi_begin();
      spi_xfer(64'h81, 8, cap, hi);
      spi_xfer(64'hFFFF_FFFF, 32, cap, hi);
      spi_end(8);
      vectors++;
      if (wr_cycles !== 1 || wr_addr !== 5'd1 || wr_data !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL midreset_next_write: got %0d pulses @%h data %h expected 1 @01 ffffffff",
                  wr_cycles, wr_addr, wr_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] cap;
      int          hi;
      clear_mon();
      spi_begin();
      spi_xfer(64'h82, 8, cap, hi);
      spi_xfer(64'hCAFE_F00D, 32, cap, hi);
      spi_end(4);
      spi_begin();
      spi_xfer(64'h02, 8, cap, hi);
      spi_xfer(64'h0, 32, cap, hi);
      spi_end(8);
      vectors++;
      if (wr_cycles !== 1 || wr_addr !== 5'd2 || wr_data !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL b2b_write: got %0d pulses @%h data %h expected 1 @02 cafef00d",
                  wr_cycles, wr_addr, wr_data);
      end
      vectors++;
      if (cap[31:0] !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL b2b_read: got %h expected cafef00d", cap[31:0]);
      end
      vectors++;
      if (abrt_cycles !== 0) begin
         miscompares++;
         $display("FAIL b2b_abrt: got %0d expected 0", abrt_cycles);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spio_hss_multiplexer_spi_reg_if.md
# spio_hss_multiplexer_spi_reg_if

SPI slave bridge that gives an external board controller access to the HSS multiplexer register bank. Sits directly upstream of the register bank and drives its register access port (`reg_write`, `reg_addr`, `reg_write_data`), returning `reg_read_data` serially on MISO. SPI pins are sampled by oversampling in the system clock domain; there is no second clock.

## Interface
Parameters:
- `REGA_BITS`, default 5: register address width; legal range 1..7.
- `REGD_BITS`, default 32: register data width; sets the data phase length in bits.

Ports:
- `clk`, in, 1: system clock. One clock only.
- `rst`, in, 1: reset, asynchronous assert, active-low (0 = reset).
- `spi_sck`, in, 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `spi_cs_n`, in, 1: chip select, active-low, asynchronous.
- `spi_mosi`, in, 1: serial data in, MSB first.
- `spi_miso`, out, 1: serial data out, MSB first. Tristating is handled outside this block.
- `reg_write`, out, 1: one-cycle write strobe to the register bank.
- `reg_addr`, out, `REGA_BITS`: register address.
- `reg_write_data`, out, `REGD_BITS`: write data.
- `reg_read_data`, in, `REGD_BITS`: combinational read data from the register bank for `reg_addr`.
- `spi_abrt`, out, 1: one-cycle pulse when a frame is aborted.

## Operation
- **Input synchronisation**: `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchroniser.
  - Flop reset values: sck 0, cs_n 1, mosi 0.
  - A third flop on sck gives rise and fall detection.
- **Frame format**: CS falls, then an 8-bit command, then `REGD_BITS` data bits.
  - Command bit 7: 1 = write, 0 = read.
  - Command bits [REGA_BITS-1:0]: address. Remaining bits are ignored.
- **States**:
  - IDLE: wait for synced cs_n = 0, then go to CMD.
  - CMD: shift MOSI in on each sck rise. On the 8th rise, latch `reg_addr` from the command and latch the R/W bit. Write goes to WDATA; read goes to RCAP.
  - RCAP: one clk. Load the read shift register from `reg_read_data`, then go to RDATA.
  - WDATA: shift MOSI in on each rise. On rise number `REGD_BITS`, drive `reg_write_data` with the assembled word and pulse `reg_write` for one clk, then go to DONE.
  - RDATA: on each sck fall, `spi_miso` takes the next shift-register bit, MSB first. On rise number `REGD_BITS`, go to DONE.
  - DONE: ignore further sck edges; synced cs_n = 1 returns to IDLE.
- **Abort**: synced cs_n = 1 in CMD, RCAP, WDATA or RDATA:
  - return to IDLE;
  - pulse `spi_abrt` for one clk;
  - no `reg_write` is issued;
  - `reg_addr` keeps its last value.
- **MISO output**: `spi_miso` is 0 in IDLE, CMD and DONE. It changes only on sck falls in RDATA, or is forced to 0 on entry to IDLE.
- **Bit counter**: counts sck rises within a phase and is cleared on every phase change and on IDLE. Width is log2(REGD_BITS)+1.
- **Read side effects**: none; reads never assert `reg_write`.
- **Reset**: reset in any state gives:
  - IDLE;
  - `spi_miso` 0, `reg_write` 0, `reg_addr` 0, `reg_write_data` 0, `spi_abrt` 0;
  - shift registers and counter at 0.

  After reset release, a frame already in progress (synced cs_n = 0) is ignored until cs_n has been seen high.

## Timing
- **Pin latency**: 2 clk from pin to synced signal; edge detect adds 1 clk.
- **SCK and CS constraints**:
  - `spi_sck` high and low times ≥ 4 clk periods each.
  - `spi_cs_n` high time between frames ≥ 4 clk.
  - CS fall to first sck rise ≥ 4 clk.
- **Write**: `reg_write` asserts 1 clk after the detected final data rise, for exactly 1 clk. `reg_addr` and `reg_write_data` are stable in that cycle and stay stable until the next frame updates them.
- **Read**:
  - `reg_addr` updates 1 clk after the 8th detected rise.
  - `reg_read_data` is captured 1 clk later (RCAP).
  - Bit MSB appears on `spi_miso` 1 clk after the detected fall that follows the 8th rise, so it is valid before the 9th rise given the sck constraint.
- **`spi_abrt`**: asserts 1 clk after the synced cs_n rise is seen mid-frame.

## Test plan
- **Write**: frame cmd 0x8A, data 0x0000_0123 → exactly one `reg_write` pulse, with `reg_addr` = 0x0A and `reg_write_data` = 0x0000_0123; `spi_abrt` stays 0.
- **Read**: frame cmd 0x03, bench drives `reg_read_data` = 0xDEAD_BEEF when `reg_addr` = 3 → MISO bits captured on sck rises 9..40 equal 0xDEAD_BEEF MSB first; `reg_write` never asserts; `spi_miso` is 0 during the command phase.
- **Abort**: write frame cmd 0x85, CS raised after 20 data bits → no `reg_write`, one-clk `spi_abrt`; a following full read of addr 5 still works.
- **Overrun**: write frame with 48 data clocks → single `reg_write` at bit 32 with the first 32 bits; the extra clocks are ignored; `spi_miso` stays 0.
- **Reset mid-frame**: `rst` = 0 during the read data phase → all outputs 0 immediately. After release the remainder of that frame produces nothing, and the next frame (write cmd 0x81, data 0xFFFF_FFFF) produces one correct write.
- **Back-to-back**: minimal CS-high gap between write addr 2 and read addr 2 → both complete; read returns the bench value for addr 2.
